// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: MIPS instruction fetch front end.
// Owns the fetch PC and issues word requests to a variable-latency
// instruction memory. Returned words and their PCs go into a circular
// queue that the downstream decode stage consumes. A redirect flushes the
// queue and restarts fetch at the new target.
// Optional feature: define INST_FETCH_QUEUE_BYPASS_EN so that a word returning
// into an empty queue is visible on inst/inst_pc in the same cycle.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_take,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic          queue_valid_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_after_s;

    // Push/pop qualification; a redirect suppresses both.
    always_comb begin
        queue_valid_s = (count_q != CNT_ZERO);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        bypass_s = (count_q == CNT_ZERO) && (state_q == ST_WAIT) && mem_ready && !redirect;
`else
        bypass_s = 1'b0;
`endif
        push_s = (state_q == ST_WAIT) && mem_ready && !redirect && !(bypass_s && inst_take);
        pop_s  = queue_valid_s && inst_take && !redirect;
        count_after_s = count_q + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end

    // Fetch FSM next state, PC registers and queue pointer updates.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            // A completing request in WAIT needs no drop phase.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            head_d     = PTR_ZERO;
            tail_d     = PTR_ZERO;
            count_d    = CNT_ZERO;
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_WAIT: state_d = mem_ready ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = mem_ready ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            if (push_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            count_d = count_after_s;
            case (state_q)
                ST_IDLE: begin
                    // Count after this cycle's pop, so a freed slot refetches at once.
                    if (count_after_s < CNT_FULL) begin
                        state_d  = ST_WAIT;
                        req_pc_d = fetch_pc_q;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (count_after_s < CNT_FULL) begin
                            state_d  = ST_WAIT;
                            req_pc_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DROP: state_d = mem_ready ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            head_q     <= PTR_ZERO;
            tail_q     <= PTR_ZERO;
            count_q    <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage: write the returned word and its PC at the tail.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 32'h0000_0000;
                pc_q[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            word_q[tail_q] <= mem_data;
            pc_q[tail_q]   <= fetch_pc_q;
        end else begin
            word_q[tail_q] <= word_q[tail_q];
            pc_q[tail_q]   <= pc_q[tail_q];
        end
    end

    // Memory request and consumer-facing outputs.
    always_comb begin
        mem_req  = (state_q != ST_IDLE);
        mem_addr = req_pc_q[31:2];
        if (bypass_s) begin
            inst_valid = 1'b1;
            inst       = mem_data;
            inst_pc    = fetch_pc_q;
        end else if (queue_valid_s) begin
            inst_valid = 1'b1;
            inst       = word_q[head_q];
            inst_pc    = pc_q[head_q];
        end else begin
            inst_valid = 1'b0;
            inst       = 32'h0000_0000;
            inst_pc    = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4, RESET_PC=0).
module tb_inst_fetch_queue;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_take;
    logic        redirect;
    logic [31:0] redirect_pc;

    int tests_run;
    int tests_failed;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_take  (inst_take),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents seen by the bench: each word encodes its own PC.
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        mem_ready    = 1'b0;
        mem_data     = 32'h0000_0000;
        inst_take    = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0000_0000;

        // Reset state
        #12;
        check_eq("rst_mem_req",    {31'd0, mem_req},    32'd0);
        check_eq("rst_mem_addr",   {2'b00, mem_addr},   32'd0);
        check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst",       inst,                32'd0);
        check_eq("rst_inst_pc",    inst_pc,             32'd0);
        reset = 1'b1;
        tick();

        // Zero-wait fill: addresses 0..3 back to back
        for (int i = 0; i < 4; i++) begin
            check_eq("fill_req",  {31'd0, mem_req},  32'd1);
            check_eq("fill_addr", {2'b00, mem_addr}, i);
            mem_ready = 1'b1;
            mem_data  = word_at(i * 4);
            tick();
        end
        mem_ready = 1'b0;
        check_eq("full_req",     {31'd0, mem_req},    32'd0);
        check_eq("full_valid",   {31'd0, inst_valid}, 32'd1);
        check_eq("full_inst_pc", inst_pc,             32'd0);
        check_eq("full_inst",    inst,                32'hA500_0000);
        tick();
        check_eq("full_hold_req", {31'd0, mem_req}, 32'd0);

        // One pop on a full queue restarts fetch at PC 16
        inst_take = 1'b1;
        tick();
        inst_take = 1'b0;
        check_eq("refill_req",  {31'd0, mem_req},  32'd1);
        check_eq("refill_addr", {2'b00, mem_addr}, 32'd4);
        check_eq("refill_pc",   inst_pc,           32'd4);
        mem_ready = 1'b1;
        mem_data  = word_at(32'd16);
        tick();
        mem_ready = 1'b0;
        check_eq("refull_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_pc",   inst_pc, 32'd4 + 32'(i) * 32'd4);
            check_eq("drain_inst", inst,    32'hA500_0004 + 32'(i) * 32'd4);
            inst_take = 1'b1;
            tick();
        end
        inst_take = 1'b0;
        check_eq("empty_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("empty_inst",  inst,                32'd0);
        check_eq("empty_pc",    inst_pc,             32'd0);
        check_eq("empty_req",   {31'd0, mem_req},    32'd1);
        check_eq("empty_addr",  {2'b00, mem_addr},   32'd5);

        // Redirect to 0x10 while waiting: old request at 0x14 is dropped
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0010;
        tick();
        redirect = 1'b0;
        check_eq("drop1_req",   {31'd0, mem_req},    32'd1);
        check_eq("drop1_addr",  {2'b00, mem_addr},   32'd5);
        check_eq("drop1_valid", {31'd0, inst_valid}, 32'd0);
        mem_ready = 1'b1;
        mem_data  = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        check_eq("drop1_done_req",   {31'd0, mem_req},    32'd0);
        check_eq("drop1_done_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("pc10_req",  {31'd0, mem_req},  32'd1);
        check_eq("pc10_addr", {2'b00, mem_addr}, 32'h4);

        // Redirect to 0x103 one cycle after the request at 0x10 rose; latency 3
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("drop2_req",  {31'd0, mem_req},  32'd1);
            check_eq("drop2_addr", {2'b00, mem_addr}, 32'h4);
            tick();
        end
        check_eq("drop2_hold_addr", {2'b00, mem_addr}, 32'h4);
        mem_ready = 1'b1;
        mem_data  = 32'h1111_1111;
        tick();
        mem_ready = 1'b0;
        check_eq("drop2_done_req",   {31'd0, mem_req},    32'd0);
        check_eq("drop2_done_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("pc100_req",  {31'd0, mem_req},  32'd1);
        check_eq("pc100_addr", {2'b00, mem_addr}, 32'h40);
        tick();
        check_eq("pc100_wait_valid", {31'd0, inst_valid}, 32'd0);
        mem_ready = 1'b1;
        mem_data  = word_at(32'h100);
        tick();
        mem_ready = 1'b0;
        check_eq("pc100_valid",  {31'd0, inst_valid}, 32'd1);
        check_eq("pc100_pc",     inst_pc,             32'h100);
        check_eq("pc100_inst",   inst,                32'hA500_0100);
        check_eq("pc104_addr",   {2'b00, mem_addr},   32'h41);

        // Redirect together with inst_take and mem_ready in WAIT
        inst_take   = 1'b1;
        mem_ready   = 1'b1;
        mem_data    = word_at(32'h104);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        inst_take = 1'b0;
        mem_ready = 1'b0;
        redirect  = 1'b0;
        check_eq("rtm_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rtm_inst",  inst,                32'd0);
        tick();
        check_eq("rtm_req",  {31'd0, mem_req},  32'd1);
        check_eq("rtm_addr", {2'b00, mem_addr}, 32'h80);
        mem_ready = 1'b1;
        mem_data  = word_at(32'h200);
        tick();
        check_eq("rtm_pc",    inst_pc,             32'h200);
        check_eq("rtm_valid2", {31'd0, inst_valid}, 32'd1);
        mem_data = word_at(32'h204);
        tick();
        mem_ready = 1'b0;
        check_eq("two_q_pc",   inst_pc,           32'h200);
        check_eq("two_q_addr", {2'b00, mem_addr}, 32'h82);

        // Asynchronous reset mid-WAIT with two entries queued
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_req",   {31'd0, mem_req},    32'd0);
        check_eq("arst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("arst_inst",  inst,                32'd0);
        check_eq("arst_pc",    inst_pc,             32'd0);
        check_eq("arst_addr",  {2'b00, mem_addr},   32'd0);
        reset = 1'b1;
        tick();
        check_eq("arst_rel_req",  {31'd0, mem_req},  32'd1);
        check_eq("arst_rel_addr", {2'b00, mem_addr}, 32'd0);

        // Empty queue, mem_ready with inst_take in the same cycle
        mem_ready = 1'b1;
        mem_data  = 32'h8C22_0004;
        inst_take = 1'b1;
        #1;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        check_eq("byp_same_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("byp_same_inst",  inst,                32'h8C22_0004);
        check_eq("byp_same_pc",    inst_pc,             32'd0);
`else
        check_eq("byp_same_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("byp_same_inst",  inst,                32'd0);
`endif
        tick();
        mem_ready = 1'b0;
        inst_take = 1'b0;
        #1;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        check_eq("byp_next_valid", {31'd0, inst_valid}, 32'd0);
`else
        check_eq("byp_next_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("byp_next_inst",  inst,                32'h8C22_0004);
        check_eq("byp_next_pc",    inst_pc,             32'd0);
`endif
        check_eq("byp_next_addr", {2'b00, mem_addr}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
